// File: rtl/score_display_scheduler_pkg.sv
// Shared Snake definitions: master-state encodings, display digit count,
// conversion FSM state enum and the double-dabble nibble adjust helper.
// No ports; imported by the scheduler and its BCD converter.
package snake_pkg;

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_PLAY = 2'b01;
  localparam logic [1:0] MS_WIN  = 2'b10;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_SHIFT = 2'd1,
    CS_DONE  = 2'd2
  } conv_state_t;

  // Add 3 to every BCD nibble that is >= 5 so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_scheduler_if.sv
// Bundle between the score/state sources and the display scheduler.
// Ports: SCORE_IN, MASTER_STATE into the scheduler; SEG_SELECT_OUT, BIN_OUT,
// BLANK_OUT, DOT_OUT, BUSY, BCD_OUT out of it. master = environment side.
interface score_display_scheduler_if #(
  parameter int SCORE_WIDTH = 8
);
  logic [SCORE_WIDTH-1:0] SCORE_IN;
  logic [1:0]             MASTER_STATE;
  logic [1:0]             SEG_SELECT_OUT;
  logic [3:0]             BIN_OUT;
  logic                   BLANK_OUT;
  logic                   DOT_OUT;
  logic                   BUSY;
  logic [15:0]            BCD_OUT;

  modport master (
    output SCORE_IN, MASTER_STATE,
    input  SEG_SELECT_OUT, BIN_OUT, BLANK_OUT, DOT_OUT, BUSY, BCD_OUT
  );

  modport slave (
    input  SCORE_IN, MASTER_STATE,
    output SEG_SELECT_OUT, BIN_OUT, BLANK_OUT, DOT_OUT, BUSY, BCD_OUT
  );
endinterface

// File: rtl/score_display_scheduler_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per cycle.
// Ports: CLOCK, RESET, score_in (binary), busy (SHIFT/DONE), bcd (4 digits).
// bcd only changes in DONE, so consumers never see a partial result.
module bin2bcd_seq
  import snake_pkg::*;
#(
  parameter int SCORE_WIDTH = 8
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic [SCORE_WIDTH-1:0] score_in,
  output logic                   busy,
  output logic [15:0]            bcd
);

  localparam logic [3:0] LAST_ITER = 4'(SCORE_WIDTH - 1);

  conv_state_t            state_q, state_d;
  logic [SCORE_WIDTH-1:0] last_q, shift_q;
  logic [15:0]            scratch_q, bcd_q;
  logic [3:0]             iter_q;
  logic [15+SCORE_WIDTH:0] shifted;

  assign shifted = {dd_adjust(scratch_q), shift_q} << 1;

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= CS_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a score that moved during SHIFT is caught back in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CS_IDLE:  if (score_in != last_q) state_d = CS_SHIFT;
      CS_SHIFT: if (iter_q == LAST_ITER) state_d = CS_DONE;
      CS_DONE:  state_d = CS_IDLE;
      default:  state_d = CS_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != CS_IDLE);
  end

  // Datapath
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      last_q    <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
    end else begin
      case (state_q)
        CS_IDLE: if (score_in != last_q) begin
          last_q    <= score_in;
          shift_q   <= score_in;
          scratch_q <= '0;
          iter_q    <= '0;
        end
        CS_SHIFT: begin
          scratch_q <= shifted[15+SCORE_WIDTH:SCORE_WIDTH];
          shift_q   <= shifted[SCORE_WIDTH-1:0];
          iter_q    <= iter_q + 4'd1;
        end
        CS_DONE: bcd_q <= scratch_q;
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_display_scheduler.sv
// Multiplexes the 4-digit seven-segment display and feeds the shared decoder.
// Ports: CLOCK, RESET, bus (slave: score/state in; select, value, blank, dot,
// busy, bcd out). Display outputs are registered, one cycle behind the index.
module score_display_scheduler
  import snake_pkg::*;
#(
  parameter int SCORE_WIDTH   = 8,
  parameter int STROBE_DIV    = 50000,
  parameter int BLINK_SLOTS   = 512,
  parameter int BLANK_LEADING = 1
) (
  input  logic CLOCK,
  input  logic RESET,
  score_display_scheduler_if.slave bus
);

  localparam int PRESC_W = $clog2(STROBE_DIV);
  localparam int BLINK_W = $clog2(2 * BLINK_SLOTS);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  logic [PRESC_W-1:0] presc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLINK_W-1:0] blink_q;
  logic               strobe;
  logic               blink_off;
  logic               busy;
  logic [15:0]        bcd;
  logic [15:0]        upper;
  logic               lz_blank;

  logic [1:0] seg_q;
  logic [3:0] bin_q;
  logic       blank_q;
  logic       dot_q;

  bin2bcd_seq #(.SCORE_WIDTH(SCORE_WIDTH)) u_bcd (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .score_in (bus.SCORE_IN),
    .busy     (busy),
    .bcd      (bcd)
  );

  assign strobe    = (presc_q == PRESC_W'(STROBE_DIV - 1));
  assign blink_off = (blink_q >= BLINK_W'(BLINK_SLOTS));

  // Digit i is a leading zero when it and every digit above it are zero.
  assign upper    = bcd >> {idx_q, 2'b00};
  assign lz_blank = (BLANK_LEADING != 0) && (idx_q != '0) && (upper == 16'd0);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      presc_q <= '0;
      idx_q   <= '0;
      blink_q <= '0;
    end else if (strobe) begin
      presc_q <= '0;
      idx_q   <= idx_q + 1'b1;
      blink_q <= (blink_q == BLINK_W'(2 * BLINK_SLOTS - 1)) ? '0 : blink_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Select, value and blank are all derived from the same idx_q sample so they
  // move together. Reserved state 2'b11 falls through as PLAY.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      seg_q   <= '0;
      bin_q   <= '0;
      blank_q <= 1'b1;
      dot_q   <= 1'b0;
    end else begin
      seg_q   <= 2'(idx_q);
      bin_q   <= bcd[{idx_q, 2'b00} +: 4];
      blank_q <= lz_blank || (bus.MASTER_STATE == MS_IDLE) ||
                 ((bus.MASTER_STATE == MS_WIN) && blink_off);
      dot_q   <= (idx_q == '0) && (bus.MASTER_STATE == MS_WIN);
    end
  end

  assign bus.SEG_SELECT_OUT = seg_q;
  assign bus.BIN_OUT        = bin_q;
  assign bus.BLANK_OUT      = blank_q;
  assign bus.DOT_OUT        = dot_q;
  assign bus.BUSY           = busy;
  assign bus.BCD_OUT        = bcd;

endmodule

// File: tb/tb_score_display_scheduler.sv
module tb_score_display_scheduler;

  localparam int SW = 8;
  localparam int SD = 4;
  localparam int BS = 2;

  logic CLOCK;
  logic RESET;

  score_display_scheduler_if #(.SCORE_WIDTH(SW)) bus_if ();

  score_display_scheduler #(
    .SCORE_WIDTH(SW), .STROBE_DIV(SD), .BLINK_SLOTS(BS), .BLANK_LEADING(1)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Decimal helpers for the reference model.
  function automatic int div_pow10(input int v, input int i);
    int r = v;
    for (int k = 0; k < i; k++) r = r / 10;
    return r;
  endfunction

  function automatic int dec_digit(input int v, input int i);
    return div_pow10(v, i) % 10;
  endfunction

  // Reference model: time since reset gives the slot; conversion is a fixed
  // delay of SW+1 edges after the edge that notices a new score.
  int edges, disp, pend, last, conv_left;
  int e_seg, e_bin, e_blank, e_dot, e_busy, e_bcd;

  always @(posedge CLOCK) begin
    int slot, i, ms, sc;
    bit boff, lz;
    ms = int'(bus_if.MASTER_STATE);
    sc = int'(bus_if.SCORE_IN);
    if (RESET) begin
      edges = 0; disp = 0; pend = 0; last = 0; conv_left = 0;
      e_seg = 0; e_bin = 0; e_blank = 1; e_dot = 0;
    end else begin
      slot = edges / SD;
      i    = slot % 4;
      boff = (slot % (2 * BS)) >= BS;
      lz   = (i > 0) && (div_pow10(disp, i) == 0);
      e_seg   = i;
      e_bin   = dec_digit(disp, i);
      e_blank = (lz || ms == 0 || (ms == 2 && boff)) ? 1 : 0;
      e_dot   = (i == 0 && ms == 2) ? 1 : 0;
      edges++;
      if (conv_left == 0) begin
        if (sc != last) begin
          last = sc; pend = sc; conv_left = SW + 1;
        end
      end else begin
        conv_left--;
        if (conv_left == 0) disp = pend;
      end
    end
    e_busy = (conv_left != 0) ? 1 : 0;
    e_bcd  = (dec_digit(disp, 3) << 12) | (dec_digit(disp, 2) << 8) |
             (dec_digit(disp, 1) << 4) | dec_digit(disp, 0);
  end

  always @(negedge CLOCK) begin
    if (chk_en) begin
      check("seg_select", int'(bus_if.SEG_SELECT_OUT), e_seg);
      check("bin",        int'(bus_if.BIN_OUT),        e_bin);
      check("blank",      int'(bus_if.BLANK_OUT),      e_blank);
      check("dot",        int'(bus_if.DOT_OUT),        e_dot);
      check("busy",       int'(bus_if.BUSY),           e_busy);
      check("bcd",        int'(bus_if.BCD_OUT),        e_bcd);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    bus_if.SCORE_IN = '0;
    bus_if.MASTER_STATE = 2'b01;
    wait_cycles(1);
    chk_en = 1;
    wait_cycles(2);
    RESET = 1'b0;
    wait_cycles(40);

    // Single conversion, then a change two cycles into a conversion.
    bus_if.SCORE_IN = 8'd237;  wait_cycles(30);
    bus_if.SCORE_IN = 8'd0;    wait_cycles(15);
    bus_if.SCORE_IN = 8'd237;  wait_cycles(2);
    bus_if.SCORE_IN = 8'd5;    wait_cycles(40);

    // Maximum value and embedded zeros.
    bus_if.SCORE_IN = 8'd255;  wait_cycles(25);
    bus_if.SCORE_IN = 8'd100;  wait_cycles(30);

    // Win blink, idle, reserved state.
    bus_if.SCORE_IN = 8'd12;
    bus_if.MASTER_STATE = 2'b10; wait_cycles(80);
    bus_if.MASTER_STATE = 2'b00; wait_cycles(20);
    bus_if.MASTER_STATE = 2'b11; wait_cycles(20);

    // Reset mid-conversion with score left at 200.
    bus_if.MASTER_STATE = 2'b01;
    bus_if.SCORE_IN = 8'd200;  wait_cycles(4);
    RESET = 1'b1;              wait_cycles(1);
    RESET = 1'b0;              wait_cycles(30);

    // Randomized stimulus.
    for (int n = 0; n < 300; n++) begin
      bus_if.SCORE_IN = SW'($urandom_range(0, 255));
      bus_if.MASTER_STATE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        RESET = 1'b1;
        wait_cycles(1);
        RESET = 1'b0;
      end
      wait_cycles($urandom_range(1, 25));
    end
    wait_cycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
